// File: rtl/data_memory.sv
// Word-addressed data memory shared by a pipeline port and a four-phase host port.
// Latency: pipeline loads return one cycle after the read edge; host access completes one edge after latching, unless stalled.
// Backpressure: the pipeline always wins; a latched host request waits in ACCESS for a cycle with mem_enable=0.
module data_memory #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 32,
    parameter int DEPTH_LOG2 = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    // pipeline port
    input  logic                  mem_enable,
    input  logic                  store_enable,
    input  logic [ADDR_WIDTH-1:0] dmem_address,
    input  logic [DATA_WIDTH-1:0] dmem_dataIn,
    output logic [DATA_WIDTH-1:0] dmem_dataOut,
    // host port
    input  logic                  host_req,
    input  logic                  host_we,
    input  logic [ADDR_WIDTH-1:0] host_addr,
    input  logic [DATA_WIDTH-1:0] host_wdata,
    output logic                  host_ack,
    output logic [DATA_WIDTH-1:0] host_rdata,
    // status
    output logic                  addr_err
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } host_state_t;

    // storage array, cleared by reset
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // host FSM state and the request captured on leaving IDLE
    host_state_t           host_state;
    logic                  host_we_q;
    logic [ADDR_WIDTH-1:0] host_addr_q;
    logic [DATA_WIDTH-1:0] host_wdata_q;

    // decoded pipeline access
    logic                  pipe_rd;
    logic                  pipe_wr;
    logic                  pipe_in_range;
    logic [DEPTH_LOG2-1:0] pipe_idx;
    logic [DATA_WIDTH-1:0] pipe_rd_dat;

    // decoded host access
    logic                  host_go;
    logic                  host_in_range;
    logic [DEPTH_LOG2-1:0] host_idx;
    logic [DATA_WIDTH-1:0] host_rd_dat;

    // Decode both ports; the host only performs its operation in ACCESS on a cycle
    // the pipeline leaves idle, so the two can never touch storage at the same edge.
    always_comb begin
        pipe_rd       = mem_enable & ~store_enable;
        pipe_wr       = mem_enable & store_enable;
        pipe_in_range = ~|dmem_address[ADDR_WIDTH-1:DEPTH_LOG2];
        pipe_idx      = dmem_address[DEPTH_LOG2-1:0];
        pipe_rd_dat   = pipe_in_range ? mem[pipe_idx] : '0;

        host_go       = (host_state == ACCESS) & ~mem_enable;
        host_in_range = ~|host_addr_q[ADDR_WIDTH-1:DEPTH_LOG2];
        host_idx      = host_addr_q[DEPTH_LOG2-1:0];
        host_rd_dat   = host_in_range ? mem[host_idx] : '0;
    end

    // Storage writes: pipeline store, else a granted host write; out-of-range writes are dropped.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (pipe_wr) begin
            if (pipe_in_range) begin
                mem[pipe_idx] <= dmem_dataIn;
            end
        end else if (host_go && host_we_q && host_in_range) begin
            mem[host_idx] <= host_wdata_q;
        end
    end

    // Pipeline load register: updated only on a pipeline read, otherwise holds.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dmem_dataOut <= '0;
        end else if (pipe_rd) begin
            dmem_dataOut <= pipe_rd_dat;
        end
    end

    // One-cycle error pulse for any out-of-range access that takes effect at this edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr_err <= 1'b0;
        end else begin
            addr_err <= (mem_enable & ~pipe_in_range) | (host_go & ~host_in_range);
        end
    end

    // Host handshake FSM: latch in IDLE, wait for a free cycle in ACCESS, hold ack in DONE until req drops.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            host_state   <= IDLE;
            host_we_q    <= 1'b0;
            host_addr_q  <= '0;
            host_wdata_q <= '0;
            host_ack     <= 1'b0;
            host_rdata   <= '0;
        end else begin
            case (host_state)
                IDLE: begin
                    host_ack <= 1'b0;
                    if (host_req) begin
                        host_we_q    <= host_we;
                        host_addr_q  <= host_addr;
                        host_wdata_q <= host_wdata;
                        host_state   <= ACCESS;
                    end
                end
                ACCESS: begin
                    // storage write happens in the storage block; here only the read data and ack
                    if (!mem_enable) begin
                        if (!host_we_q) begin
                            host_rdata <= host_rd_dat;
                        end
                        host_ack   <= 1'b1;
                        host_state <= DONE;
                    end
                end
                DONE: begin
                    if (!host_req) begin
                        host_ack   <= 1'b0;
                        host_state <= IDLE;
                    end
                end
                default: begin
                    host_ack   <= 1'b0;
                    host_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_data_memory.sv
// Directed bench for data_memory: pipeline store/load, range errors, host handshake,
// contention, reset abort and a full back-to-back sweep, all with hand-computed expectations.
`timescale 1ns/1ps
module tb_data_memory;

    localparam int DW = 64;
    localparam int AW = 32;

    logic          clk;
    logic          rst;
    logic          mem_enable;
    logic          store_enable;
    logic [AW-1:0] dmem_address;
    logic [DW-1:0] dmem_dataIn;
    logic [DW-1:0] dmem_dataOut;
    logic          host_req;
    logic          host_we;
    logic [AW-1:0] host_addr;
    logic [DW-1:0] host_wdata;
    logic          host_ack;
    logic [DW-1:0] host_rdata;
    logic          addr_err;

    int total;
    int bad;

    data_memory #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH_LOG2(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .mem_enable   (mem_enable),
        .store_enable (store_enable),
        .dmem_address (dmem_address),
        .dmem_dataIn  (dmem_dataIn),
        .dmem_dataOut (dmem_dataOut),
        .host_req     (host_req),
        .host_we      (host_we),
        .host_addr    (host_addr),
        .host_wdata   (host_wdata),
        .host_ack     (host_ack),
        .host_rdata   (host_rdata),
        .addr_err     (addr_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // advance to 1ns after the next rising edge; inputs are driven and outputs sampled there
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pipe(input logic en, input logic st, input logic [AW-1:0] a, input logic [DW-1:0] d);
        mem_enable   = en;
        store_enable = st;
        dmem_address = a;
        dmem_dataIn  = d;
    endtask

    task automatic host(input logic rq, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        host_req   = rq;
        host_we    = we;
        host_addr  = a;
        host_wdata = d;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        pipe(1'b0, 1'b0, '0, '0);
        host(1'b0, 1'b0, '0, '0);
        #2 rst = 1'b0;
        tick();
        tick();
        check("rst_dout", dmem_dataOut, '0);
        check("rst_ack", {63'd0, host_ack}, '0);
        check("rst_rdata", host_rdata, '0);
        check("rst_err", {63'd0, addr_err}, '0);
        rst = 1'b1;

        // pipeline store then load of the same address on the next cycle
        pipe(1'b1, 1'b1, 32'd5, 64'hDEADBEEF_CAFEF00D);
        tick();
        pipe(1'b1, 1'b0, 32'd5, 64'h0);
        tick();
        check("ld5", dmem_dataOut, 64'hDEADBEEF_CAFEF00D);
        check("ld5_err", {63'd0, addr_err}, '0);
        pipe(1'b0, 1'b1, 32'd6, 64'h1111_2222_3333_4444);
        tick();
        check("hold1", dmem_dataOut, 64'hDEADBEEF_CAFEF00D);
        tick();
        check("hold2", dmem_dataOut, 64'hDEADBEEF_CAFEF00D);

        // out-of-range store and load
        pipe(1'b1, 1'b1, 32'h100, 64'h5555);
        tick();
        check("oob_st_err", {63'd0, addr_err}, 64'd1);
        pipe(1'b1, 1'b0, 32'h100, 64'h0);
        tick();
        check("oob_ld_err", {63'd0, addr_err}, 64'd1);
        check("oob_ld_dat", dmem_dataOut, '0);
        pipe(1'b1, 1'b0, 32'h0, 64'h0);
        tick();
        check("a0_err", {63'd0, addr_err}, '0);
        check("a0_dat", dmem_dataOut, '0);
        pipe(1'b0, 1'b0, '0, '0);
        tick();
        check("err_clear", {63'd0, addr_err}, '0);

        // host write, inputs changed after latch must be ignored
        host(1'b1, 1'b1, 32'd7, 64'h1234);
        tick();
        check("hw_noack", {63'd0, host_ack}, '0);
        host(1'b1, 1'b1, 32'd9, 64'hBAD);
        tick();
        check("hw_ack", {63'd0, host_ack}, 64'd1);
        host(1'b0, 1'b0, '0, '0);
        tick();
        check("hw_ackdrop", {63'd0, host_ack}, '0);
        // host read back
        host(1'b1, 1'b0, 32'd7, '0);
        tick();
        tick();
        check("hr_ack", {63'd0, host_ack}, 64'd1);
        check("hr_dat", host_rdata, 64'h1234);
        host(1'b0, 1'b0, '0, '0);
        tick();
        check("hr_ackdrop", {63'd0, host_ack}, '0);
        check("hr_hold", host_rdata, 64'h1234);
        pipe(1'b1, 1'b0, 32'd7, '0);
        tick();
        check("p_rd7", dmem_dataOut, 64'h1234);
        pipe(1'b1, 1'b0, 32'd9, '0);
        tick();
        check("p_rd9", dmem_dataOut, '0);
        pipe(1'b0, 1'b0, '0, '0);

        // contention: pipeline busy for three edges, host stalled
        pipe(1'b1, 1'b1, 32'd10, 64'hA5A5);
        host(1'b1, 1'b1, 32'd11, 64'h77);
        tick();
        check("ct_noack1", {63'd0, host_ack}, '0);
        tick();
        check("ct_noack2", {63'd0, host_ack}, '0);
        tick();
        check("ct_noack3", {63'd0, host_ack}, '0);
        pipe(1'b0, 1'b0, '0, '0);
        tick();
        check("ct_ack", {63'd0, host_ack}, 64'd1);
        host(1'b0, 1'b0, '0, '0);
        tick();
        pipe(1'b1, 1'b0, 32'd10, '0);
        tick();
        check("ct_rd10", dmem_dataOut, 64'hA5A5);
        pipe(1'b1, 1'b0, 32'd11, '0);
        tick();
        check("ct_rd11", dmem_dataOut, 64'h77);
        pipe(1'b0, 1'b0, '0, '0);

        // reset while a host write sits in ACCESS
        host(1'b1, 1'b1, 32'd3, 64'hFF);
        tick();
        rst = 1'b0;
        host(1'b0, 1'b0, '0, '0);
        #1;
        check("ra_ack_async", {63'd0, host_ack}, '0);
        check("ra_dout_async", dmem_dataOut, '0);
        check("ra_rdata_async", host_rdata, '0);
        tick();
        rst = 1'b1;
        tick();
        tick();
        check("ra_ack", {63'd0, host_ack}, '0);
        pipe(1'b1, 1'b0, 32'd3, '0);
        tick();
        check("ra_rd3", dmem_dataOut, '0);
        pipe(1'b1, 1'b0, 32'd10, '0);
        tick();
        check("ra_rd10", dmem_dataOut, '0);
        pipe(1'b0, 1'b0, '0, '0);
        // FSM back in IDLE: a fresh host read completes in two edges
        host(1'b1, 1'b0, 32'd3, '0);
        tick();
        check("ra_idle_noack", {63'd0, host_ack}, '0);
        tick();
        check("ra_idle_ack", {63'd0, host_ack}, 64'd1);
        host(1'b0, 1'b0, '0, '0);
        tick();

        // back-to-back store/load sweep, pattern addr*3
        for (int a = 0; a < 256; a++) begin
            pipe(1'b1, 1'b1, a, 64'(a * 3));
            tick();
            check("b2b_st_err", {63'd0, addr_err}, '0);
            pipe(1'b1, 1'b0, a, '0);
            tick();
            check("b2b_ld", dmem_dataOut, 64'(a * 3));
            check("b2b_ld_err", {63'd0, addr_err}, '0);
        end
        pipe(1'b0, 1'b0, '0, '0);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/data_memory.md
DATA_MEMORY -- requirements
Module: data_memory

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 64, word width in bits.
REQ-002 SHALL have parameter ADDR_WIDTH, default 32, width of every address port.
REQ-003 SHALL have parameter DEPTH_LOG2, default 8, log2 of the word count (256 words).
REQ-004 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous and active-low.
REQ-006 SHALL have port mem_enable  input  1  pipeline access request, sampled each edge.
REQ-007 SHALL have port store_enable  input  1  pipeline write when 1, read when 0; qualified by mem_enable.
REQ-008 SHALL have port dmem_address  input  ADDR_WIDTH  pipeline word address.
REQ-009 SHALL have port dmem_dataIn  input  DATA_WIDTH  pipeline store data.
REQ-010 SHALL have port dmem_dataOut  output  DATA_WIDTH  registered pipeline load data.
REQ-011 SHALL have port host_req  input  1  host access request, four-phase handshake.
REQ-012 SHALL have port host_we  input  1  host write when 1, read when 0.
REQ-013 SHALL have port host_addr  input  ADDR_WIDTH  host word address.
REQ-014 SHALL have port host_wdata  input  DATA_WIDTH  host write data.
REQ-015 SHALL have port host_ack  output  1  host access complete.
REQ-016 SHALL have port host_rdata  output  DATA_WIDTH  host read data, valid while host_ack=1.
REQ-017 SHALL have port addr_err  output  1  one-cycle pulse on an out-of-range access.

Function
REQ-018 SHALL index storage with address[DEPTH_LOG2-1:0]; an address with any bit above DEPTH_LOG2-1 set is out of range.
REQ-019 SHALL write dmem_dataIn at the edge where mem_enable=1 and store_enable=1, if in range.
REQ-020 SHALL load dmem_dataOut at the edge where mem_enable=1 and store_enable=0 (one-cycle latency, valid for the downstream stage the next cycle).
REQ-021 SHALL hold dmem_dataOut unchanged on cycles without a pipeline read.
REQ-022 SHALL make a store immediately visible: a read of the same address in the next cycle returns the new data.
REQ-023 SHALL, on an out-of-range read (pipeline or host), return 0; on an out-of-range write, leave storage unchanged; in both cases pulse addr_err high for the cycle after the edge.
REQ-024 SHALL run a host FSM with states IDLE, ACCESS and DONE.
REQ-025 IDLE: when host_req=1, SHALL latch host_we, host_addr and host_wdata and go to ACCESS.
REQ-026 ACCESS: when mem_enable=0, SHALL perform the latched operation at the edge, load host_rdata (reads only) and go to DONE; when mem_enable=1, SHALL stay in ACCESS (the pipeline has priority and the host is stalled).
REQ-027 DONE: host_ack SHALL be 1; on host_req=0, host_ack SHALL drop and the FSM SHALL return to IDLE; host_rdata SHALL hold until the next host read completes.
REQ-028 SHALL ignore changes to host inputs after they are latched in IDLE.
REQ-029 SHALL never let a host and a pipeline access take effect at the same edge; the pipeline always wins.

Reset
REQ-030 While rst=0, SHALL asynchronously clear all storage words to 0, dmem_dataOut to 0, host_rdata to 0, host_ack to 0 and addr_err to 0, and force the FSM to IDLE.
REQ-031 Reset asserted mid host access SHALL abort it: no write occurs and ack does not rise after release.
REQ-032 After rst rises, the first access SHALL be accepted at the next rising edge.

Verification
REQ-033 Pipeline store then load: store 0xDEADBEEF_CAFEF00D to addr 5, read addr 5 next cycle -> dmem_dataOut = 0xDEADBEEF_CAFEF00D one cycle after the read edge; it holds while mem_enable=0.
REQ-034 Out of range: pipeline store to addr 0x100, then read addr 0x100 and addr 0 -> addr_err pulses twice, read data is 0 and addr 0 is unchanged (0).
REQ-035 Host write/read: host writes 0x1234 to addr 7 (ack seen, req dropped), then host reads addr 7 -> host_rdata = 0x1234 with host_ack=1; pipeline read of addr 7 -> 0x1234.
REQ-036 Contention: host_req with mem_enable=1 for 3 cycles -> FSM held in ACCESS, no ack; the pipeline store lands; host_ack rises 1 cycle after mem_enable drops.
REQ-037 Reset mid-access: host write of 0xFF to addr 3, rst=0 while in ACCESS -> after release addr 3 reads 0, host_ack=0, FSM in IDLE.
REQ-038 Back-to-back: pipeline alternates store/load over addrs 0..255 with pattern addr*3 -> every load matches, no addr_err.
